// File: rtl/inport_sampler.sv
// Synchronises and debounces switches/keys into the 16-bit inport word; optional key-press latch via INPORT_KEY_LATCH_EN.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from pin to inport_export; no backpressure, outputs are plain levels/pulses.
module inport_sampler #(
    parameter int NUM_SW          = 12,
    parameter int NUM_KEY         = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  raw_sw,
    input  logic [NUM_KEY-1:0] raw_key,
    input  logic [NUM_KEY-1:0] event_clr,
    output logic [15:0]        inport_export,
    output logic [NUM_KEY-1:0] key_press
);

    localparam int NUM_CH = NUM_SW + NUM_KEY;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (NUM_CH != 16) begin : g_bad_width
            $error("inport_sampler: NUM_SW + NUM_KEY must equal 16");
        end
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("inport_sampler: DEBOUNCE_CYCLES must be at least 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("inport_sampler: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][NUM_SW-1:0]  sw_sync;
    logic [SYNC_STAGES-1:0][NUM_KEY-1:0] key_sync;
    logic [NUM_CH-1:0]                   lvl;
    logic [NUM_CH-1:0]                   db;
    logic [NUM_CH-1:0][CW-1:0]           cnt;
    logic [NUM_KEY-1:0]                  db_key;
    logic [NUM_KEY-1:0]                  db_key_d;
    logic [NUM_KEY-1:0]                  press_now;
    logic [NUM_KEY-1:0]                  key_bits;

    // Key synchronisers reset to 1 so the pins read as released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_sync  <= '0;
            key_sync <= '1;
        end else begin
            sw_sync  <= {sw_sync[SYNC_STAGES-2:0], raw_sw};
            key_sync <= {key_sync[SYNC_STAGES-2:0], raw_key};
        end
    end

    assign lvl = {~key_sync[SYNC_STAGES-1], sw_sync[SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            db  <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (lvl[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= lvl[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign db_key    = db[NUM_CH-1:NUM_SW];
    assign press_now = db_key & ~db_key_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            db_key_d  <= '0;
            key_press <= '0;
        end else begin
            db_key_d  <= db_key;
            key_press <= press_now;
        end
    end

`ifdef INPORT_KEY_LATCH_EN
    logic [NUM_KEY-1:0] key_latch;

    // Set has priority over clear so a press coinciding with a clear is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_latch <= '0;
        end else begin
            key_latch <= (key_latch & ~event_clr) | press_now;
        end
    end

    assign key_bits = key_latch;
`else
    logic unused_event_clr;

    assign unused_event_clr = ^event_clr;
    assign key_bits         = db_key;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            inport_export <= 16'h0000;
        end else begin
            inport_export <= {key_bits, db[NUM_SW-1:0]};
        end
    end

endmodule

// File: tb/tb_inport_sampler.sv
// Directed bench for inport_sampler with DEBOUNCE_CYCLES=8, SYNC_STAGES=2; expectations are scheduled by edge number.
module tb_inport_sampler;

    typedef struct {
        int          due;
        logic [15:0] inport;
        logic [3:0]  press;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [11:0] raw_sw;
    logic [3:0]  raw_key;
    logic [3:0]  event_clr;
    logic [15:0] inport_export;
    logic [3:0]  key_press;

    exp_t sb[$];
    exp_t cur;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   c;

    inport_sampler #(
        .NUM_SW(12),
        .NUM_KEY(4),
        .DEBOUNCE_CYCLES(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_sw(raw_sw),
        .raw_key(raw_key),
        .event_clr(event_clr),
        .inport_export(inport_export),
        .key_press(key_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sched(input int due, input logic [15:0] v, input logic [3:0] p);
        exp_t e;
        e.due    = due;
        e.inport = v;
        e.press  = p;
        sb.push_back(e);
    endtask

    // Advance one edge, retire any expectations due on it, then compare both outputs.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
        end
        vectors++;
        assert (inport_export === cur.inport) else begin
            miscompares++;
            $error("FAIL inport_export edge=%0d observed=%h expected=%h", cyc, inport_export, cur.inport);
        end
        vectors++;
        assert (key_press === cur.press) else begin
            miscompares++;
            $error("FAIL key_press edge=%0d observed=%b expected=%b", cyc, key_press, cur.press);
        end
    endtask

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        cur.due     = 0;
        cur.inport  = 16'h0000;
        cur.press   = 4'h0;
        reset       = 1'b1;
        raw_sw      = 12'hFFF;
        raw_key     = 4'hF;
        event_clr   = 4'h0;

        // Reset with switches up: zero during reset, 0FFF exactly 11 edges after release.
        repeat (3) step();
        reset = 1'b0;
        sched(cyc + 11, 16'h0FFF, 4'h0);
        repeat (14) step();

        // Bring switch 0 down, then bounce it up/down/up with 5-cycle gaps.
        raw_sw = 12'hFFE;
        sched(cyc + 11, 16'h0FFE, 4'h0);
        repeat (14) step();
        raw_sw = 12'hFFF;
        repeat (5) step();
        raw_sw = 12'hFFE;
        repeat (5) step();
        raw_sw = 12'hFFF;
        sched(cyc + 11, 16'h0FFF, 4'h0);
        repeat (14) step();

        // Key 2 held for 30 cycles.
        raw_key = 4'hB;
        c = cyc;
`ifdef INPORT_KEY_LATCH_EN
        sched(c + 11, 16'h0FFF, 4'h4);
        sched(c + 12, 16'h4FFF, 4'h0);
        repeat (30) step();
`else
        sched(c + 11, 16'h4FFF, 4'h4);
        sched(c + 12, 16'h4FFF, 4'h0);
        repeat (20) step();
        event_clr = 4'hF;
        step();
        event_clr = 4'h0;
        repeat (9) step();
`endif
        raw_key = 4'hF;
`ifdef INPORT_KEY_LATCH_EN
        repeat (14) step();
        event_clr = 4'h4;
        step();
        event_clr = 4'h0;
        sched(cyc + 1, 16'h0FFF, 4'h0);
        repeat (3) step();
`else
        sched(cyc + 11, 16'h0FFF, 4'h0);
        repeat (14) step();
`endif

        // All 16 channels change on the same edge.
        raw_sw  = 12'h5A5;
        raw_key = 4'h6;
        c = cyc;
`ifdef INPORT_KEY_LATCH_EN
        sched(c + 11, 16'h05A5, 4'h9);
`else
        sched(c + 11, 16'h95A5, 4'h9);
`endif
        sched(c + 12, 16'h95A5, 4'h0);
        repeat (20) step();
        raw_sw  = 12'hFFF;
        raw_key = 4'hF;
`ifdef INPORT_KEY_LATCH_EN
        sched(cyc + 11, 16'h9FFF, 4'h0);
        repeat (14) step();
        event_clr = 4'h1;
        step();
        event_clr = 4'h0;
        sched(cyc + 1, 16'h8FFF, 4'h0);
        repeat (2) step();
        event_clr = 4'h8;
        step();
        event_clr = 4'h0;
        sched(cyc + 1, 16'h0FFF, 4'h0);
        repeat (3) step();

        // Clear of key 0 coincides with its press being generated: press wins.
        raw_key = 4'hE;
        c = cyc;
        sched(c + 11, 16'h0FFF, 4'h1);
        sched(c + 12, 16'h1FFF, 4'h0);
        repeat (10) step();
        event_clr = 4'h1;
        step();
        event_clr = 4'h0;
        repeat (6) step();
        raw_key = 4'hF;
        repeat (14) step();
`else
        sched(cyc + 11, 16'h0FFF, 4'h0);
        repeat (14) step();
`endif

        // Switch 5 drops, reset hits with its counter at 4; full requalification afterwards.
        raw_sw = 12'hFDF;
        repeat (6) step();
        reset = 1'b1;
        sched(cyc + 1, 16'h0000, 4'h0);
        repeat (2) step();
        reset = 1'b0;
        sched(cyc + 11, 16'h0FDF, 4'h0);
        repeat (14) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inport_sampler.md
# inport_sampler

Conditions the board's raw slide switches and push-buttons into the 16-bit word that feeds the host-readable `inport` PIO of the PCIe system. It is the FPGA-side producer for the input port the host driver polls: it synchronises, debounces and optionally latches key-press events, so the host sees clean, glitch-free values. It sits between the board pins and the system's `inport_external_connection_export` input.

## Interface
- `NUM_SW`, 12: number of slide-switch inputs; `NUM_SW + NUM_KEY` must equal 16 (elaboration error otherwise).
- `NUM_KEY`, 4: number of push-button inputs.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a new level (1 ms at 50 MHz); minimum 2.
- `SYNC_STAGES`, 2: synchroniser depth; minimum 2.

- `clk`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `raw_sw`  in  NUM_SW: asynchronous switch pins; 1 = up.
- `raw_key`  in  NUM_KEY: asynchronous push-button pins; active-low (0 = pressed).
- `event_clr`  in  NUM_KEY: per-key one-cycle clear of the latched press event (used only with the latch feature).
- `inport_export`  out  16: `{key_bits[NUM_KEY-1:0], sw_db[NUM_SW-1:0]}`, to the system's `inport` PIO.
- `key_press`  out  NUM_KEY: one-cycle pulse per debounced key press (0→1 of the pressed state).

## Operation
- Synchroniser: `SYNC_STAGES` flops per bit. Keys are inverted after the last stage, so internal key level 1 means pressed.
- Debounce, per bit (16 independent channels): registered accepted level `db` and counter `cnt` with width `$clog2(DEBOUNCE_CYCLES)`.
  - If the synchronised level equals `db`: `cnt` ← 0.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `db` ← synchronised level and `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt+1`.
  - Any single-cycle mismatch shorter than `DEBOUNCE_CYCLES` never changes `db`.
- Press detect: `key_press[i]` is registered and equals `db_key[i] & ~db_key_d[i]`, where `db_key_d` is `db_key` delayed by one cycle. Releases produce no pulse.
- `key_bits`: either the live `db_key` level or the latched event (see Configuration).
- `inport_export` is registered and takes the new `db`/`key_bits` one cycle after they update.
- Reset values:
  - Switch synchroniser flops: 0.
  - Key synchroniser flops: 1 (released).
  - All `db`: 0. All `cnt`: 0. `db_key_d`: 0. Event latches: 0.
  - `inport_export`: 16'h0000. `key_press`: 0.
- Reset asserted mid-debounce discards the partial count. After reset is released, input levels are re-qualified from zero, so a switch already up is accepted only after the full latency.

## Timing
- Latency is measured from the first rising edge that samples a changed raw level, with the raw level held stable:
  - `db` updates at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
  - `inport_export` updates at edge `SYNC_STAGES + DEBOUNCE_CYCLES + 1`.
  - `key_press` asserts on the same edge as `inport_export` and lasts exactly one cycle.
- A bounce back to the old level before `cnt` reaches `DEBOUNCE_CYCLES-1` restarts qualification from 0 on the next edge.
- Channels are independent: simultaneous changes on several bits, for example all 16, each resolve with the same latency.
- `event_clr` is sampled every cycle. It has no effect when the latch feature is compiled out.

## Configuration
- `INPORT_KEY_LATCH_EN` defined:
  - `key_bits[i]` is a sticky flag, set on the cycle `key_press[i]` is generated and cleared by `event_clr[i]`.
  - If set and clear coincide, set wins, so no press is lost.
  - The flag stays 1 after the key is released until it is cleared.
  - Latch changes reach `inport_export` one cycle later.
- Not defined:
  - `key_bits = db_key`, the live debounced pressed level.
  - The latch registers and `event_clr` logic are absent; the port is kept and ignored.

## Test plan
Bench settings: `DEBOUNCE_CYCLES=8`, `SYNC_STAGES=2`.
- Reset: hold `reset` for 3 cycles with `raw_sw=12'hFFF` and `raw_key=4'hF`. Expect `inport_export=16'h0000` and `key_press=0` during reset. After release, expect `inport_export=16'h0FFF` exactly 11 edges later and never earlier.
- Bounce rejection: `raw_sw[0]` goes 0→1, 1→0 and 0→1 with 5-cycle gaps, then stays 1. Expect no change at any gap. Expect bit 0 to rise exactly 11 edges after the final 0→1.
- Key press, latch compiled out: drive `raw_key[2]` to 0 for 30 cycles, then back to 1. Expect `inport_export[14]` high for 30 cycles, offset by 11 edges. Expect one `key_press[2]` pulse, one cycle wide, aligned with the rise.
- Key latch, `INPORT_KEY_LATCH_EN` defined: press and release `raw_key[0]`. Expect `inport_export[12]` to stay 1 after release. Pulse `event_clr[0]` and expect bit 12 to be 0 one cycle later.
- Set and clear together (latch on): assert `event_clr[0]` on the same cycle `key_press[0]` is generated. Expect `inport_export[12]` = 1.
- Reset mid-debounce: change `raw_sw[5]`, then assert `reset` at count 4. Expect bit 5 = 0 after reset, and full 11-edge re-qualification afterwards.
